// File: rtl/fetch_pkg.sv
// fetch_pkg: shared branch-op and FSM state types for the fetch unit
package fetch_pkg;
   typedef enum logic [2:0] {NONE, JMP_ABS, JMP_REL, CALL, RET, HALT} br_op_t;
   typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: control-unit / fetch-unit bundle; master drives requests, slave returns fetch state
interface fetch_if
   import fetch_pkg::*;
#(
   parameter int PC_W = 10,
   parameter int LUT_PTR_W = 4,
   parameter int OFF_W = 6
);
   logic start;
   logic stall;
   br_op_t br_op;
   logic br_taken;
   logic [LUT_PTR_W-1:0] lut_ptr;
   logic [OFF_W-1:0] rel_off;
   logic lut_wr_en;
   logic [LUT_PTR_W-1:0] lut_wr_addr;
   logic [PC_W-1:0] lut_wr_data;
   logic [PC_W-1:0] prog_ctr;
   logic fetch_valid;
   logic done;
   logic ras_err;
   modport master (
      output start, stall, br_op, br_taken, lut_ptr, rel_off, lut_wr_en, lut_wr_addr, lut_wr_data,
      input prog_ctr, fetch_valid, done, ras_err
   );
   modport slave (
      input start, stall, br_op, br_taken, lut_ptr, rel_off, lut_wr_en, lut_wr_addr, lut_wr_data,
      output prog_ctr, fetch_valid, done, ras_err
   );
endinterface

// File: rtl/ret_stack.sv
// ret_stack: return-address LIFO; callers guarantee push and pop are never both high
module ret_stack #(
   parameter int DEPTH = 4,
   parameter int W = 10
) (
   input logic clk,
   input logic reset,
   input logic push,
   input logic pop,
   input logic clear,
   input logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic full,
   output logic empty
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [W-1:0] mem [DEPTH];
   logic [CW-1:0] cnt;
   assign full = cnt == CW'(DEPTH);
   assign empty = cnt == '0;
   assign dout = mem[AW'(cnt - 1'b1)];
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else cnt <= clear ? '0 : (push && !full) ? cnt + 1'b1 : (pop && !empty) ? cnt - 1'b1 : cnt;
   // Storage needs no reset: only entries below cnt are ever read
   always_ff @(posedge clk)
      if (push && !full && !clear) mem[AW'(cnt)] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter with writable jump LUT, return stack and start/done handshake
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int PC_W = 10,
   parameter int LUT_PTR_W = 4,
   parameter int OFF_W = 6,
   parameter int RAS_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_VEC = '0,
   parameter logic [PC_W-1:0] LAST_ADDR = '1
) (
   input logic clk,
   input logic reset,
   fetch_if.slave bus
);
   fetch_state_t state, state_nx;
   logic [PC_W-1:0] lut [2**LUT_PTR_W];
   logic [PC_W-1:0] pc_nx, pc_inc, lut_rd, ras_dout;
   logic push, pop, full, empty, err_set, seq_adv;
   assign pc_inc = bus.prog_ctr + 1'b1;
   assign lut_rd = lut[bus.lut_ptr];
   // Only a plain advance (NONE or a not-taken conditional jump) can run off the end
   assign seq_adv = (bus.br_op == JMP_ABS || bus.br_op == JMP_REL) ? !bus.br_taken
                                                                  : !(bus.br_op inside {CALL, RET, HALT});
   always_comb begin
      state_nx = state;
      pc_nx = bus.prog_ctr;
      push = 1'b0;
      pop = 1'b0;
      err_set = 1'b0;
      if (bus.start) begin
         state_nx = RUN;
         pc_nx = RESET_VEC;
      end else if (state == RUN && !bus.stall) begin
         case (bus.br_op)
            JMP_ABS: pc_nx = bus.br_taken ? lut_rd : pc_inc;
            JMP_REL: pc_nx = bus.br_taken ? bus.prog_ctr + PC_W'($signed(bus.rel_off)) : pc_inc;
            CALL: begin
               pc_nx = lut_rd;
               push = !full;
               err_set = full;
            end
            RET: begin
               pc_nx = empty ? pc_inc : ras_dout;
               pop = !empty;
               err_set = empty;
            end
            HALT: state_nx = HALTED;
            default: pc_nx = pc_inc;
         endcase
         if (seq_adv && bus.prog_ctr == LAST_ADDR) begin
            state_nx = HALTED;
            pc_nx = bus.prog_ctr;
         end
      end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         bus.prog_ctr <= '0;
         bus.fetch_valid <= 1'b0;
         bus.done <= 1'b0;
         bus.ras_err <= 1'b0;
      end else begin
         state <= state_nx;
         bus.prog_ctr <= pc_nx;
         bus.fetch_valid <= state_nx == RUN;
         bus.done <= state_nx == HALTED;
         bus.ras_err <= !bus.start && (bus.ras_err || err_set);
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) for (int i = 0; i < 2**LUT_PTR_W; i++) lut[i] <= '0;
      else if (bus.lut_wr_en) lut[bus.lut_wr_addr] <= bus.lut_wr_data;
   ret_stack #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
      .clk(clk),
      .reset(reset),
      .push(push),
      .pop(pop),
      .clear(bus.start),
      .din(pc_inc),
      .dout(ras_dout),
      .full(full),
      .empty(empty)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand sequences for mid-run reset
module tb_fetch_unit;
   import fetch_pkg::*;
   typedef struct {
      logic st, sl;
      br_op_t op;
      logic tk;
      logic [3:0] ptr;
      logic [5:0] off;
      logic we;
      logic [3:0] wa;
      logic [9:0] wd;
      logic [9:0] pc;
      logic v, d, e;
   } vec_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_tests = 0;
   int n_fail = 0;
   vec_t tbl[$];
   fetch_if #(.PC_W(10), .LUT_PTR_W(4), .OFF_W(6)) bus ();
   fetch_unit #(.LAST_ADDR(10'h00F)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   function automatic vec_t mk(logic st, logic sl, br_op_t op, logic tk, logic [3:0] ptr, logic [5:0] off,
                               logic we, logic [3:0] wa, logic [9:0] wd, logic [9:0] pc, logic v, logic d, logic e);
      vec_t r;
      r = '{st, sl, op, tk, ptr, off, we, wa, wd, pc, v, d, e};
      return r;
   endfunction
   task automatic drive(vec_t r);
      bus.start = r.st;
      bus.stall = r.sl;
      bus.br_op = r.op;
      bus.br_taken = r.tk;
      bus.lut_ptr = r.ptr;
      bus.rel_off = r.off;
      bus.lut_wr_en = r.we;
      bus.lut_wr_addr = r.wa;
      bus.lut_wr_data = r.wd;
   endtask
   task automatic check(string name, logic [9:0] pc, logic v, logic d, logic e);
      n_tests++;
      if ({bus.prog_ctr, bus.fetch_valid, bus.done, bus.ras_err} !== {pc, v, d, e}) begin
         n_fail++;
         $display("FAIL %s: got pc=%h valid=%b done=%b err=%b, want pc=%h valid=%b done=%b err=%b",
                  name, bus.prog_ctr, bus.fetch_valid, bus.done, bus.ras_err, pc, v, d, e);
      end
   endtask
   task automatic step(vec_t r, string name);
      @(negedge clk);
      drive(r);
      @(posedge clk);
      #1 check(name, r.pc, r.v, r.d, r.e);
   endtask
   initial begin
      // st sl op tk ptr off we wa wd | pc v d e
      tbl.push_back(mk(0, 0, NONE,    0, 0,  0,     1, 5,  10'h120, 10'h000, 0, 0, 0)); // idle ignores op, LUT write lands
      tbl.push_back(mk(1, 0, NONE,    0, 0,  0,     0, 0,  0,       10'h000, 1, 0, 0));
      tbl.push_back(mk(0, 0, NONE,    0, 0,  0,     0, 0,  0,       10'h001, 1, 0, 0));
      tbl.push_back(mk(0, 0, NONE,    0, 0,  0,     0, 0,  0,       10'h002, 1, 0, 0));
      tbl.push_back(mk(0, 0, NONE,    0, 0,  0,     0, 0,  0,       10'h003, 1, 0, 0));
      tbl.push_back(mk(0, 0, JMP_ABS, 1, 5,  0,     0, 0,  0,       10'h120, 1, 0, 0));
      tbl.push_back(mk(0, 0, JMP_ABS, 0, 5,  0,     0, 0,  0,       10'h121, 1, 0, 0));
      tbl.push_back(mk(0, 0, JMP_ABS, 1, 5,  0,     1, 5,  10'h200, 10'h120, 1, 0, 0)); // read-during-write: old
      tbl.push_back(mk(0, 0, JMP_ABS, 1, 5,  0,     1, 1,  10'h3FE, 10'h200, 1, 0, 0));
      tbl.push_back(mk(0, 0, JMP_ABS, 1, 1,  0,     1, 2,  10'h010, 10'h3FE, 1, 0, 0));
      tbl.push_back(mk(0, 0, JMP_REL, 1, 0,  6'd3,  1, 3,  10'h020, 10'h001, 1, 0, 0));
      tbl.push_back(mk(0, 0, NONE,    0, 0,  0,     1, 4,  10'h030, 10'h002, 1, 0, 0));
      tbl.push_back(mk(0, 0, JMP_REL, 1, 0,  6'h3C, 1, 6,  10'h040, 10'h3FE, 1, 0, 0));
      tbl.push_back(mk(0, 0, JMP_REL, 0, 0,  6'd3,  1, 7,  10'h050, 10'h3FF, 1, 0, 0));
      tbl.push_back(mk(0, 0, NONE,    0, 0,  0,     1, 8,  10'h100, 10'h000, 1, 0, 0));
      tbl.push_back(mk(0, 0, JMP_ABS, 1, 2,  0,     1, 10, 10'h00E, 10'h010, 1, 0, 0));
      tbl.push_back(mk(0, 0, CALL,    0, 3,  0,     0, 0,  0,       10'h020, 1, 0, 0));
      tbl.push_back(mk(0, 0, CALL,    0, 4,  0,     0, 0,  0,       10'h030, 1, 0, 0));
      tbl.push_back(mk(0, 0, CALL,    0, 6,  0,     0, 0,  0,       10'h040, 1, 0, 0));
      tbl.push_back(mk(0, 0, CALL,    0, 7,  0,     0, 0,  0,       10'h050, 1, 0, 0));
      tbl.push_back(mk(0, 0, RET,     0, 0,  0,     0, 0,  0,       10'h041, 1, 0, 0));
      tbl.push_back(mk(0, 0, RET,     0, 0,  0,     0, 0,  0,       10'h031, 1, 0, 0));
      tbl.push_back(mk(0, 0, RET,     0, 0,  0,     0, 0,  0,       10'h021, 1, 0, 0));
      tbl.push_back(mk(0, 0, RET,     0, 0,  0,     0, 0,  0,       10'h011, 1, 0, 0));
      tbl.push_back(mk(0, 0, RET,     0, 0,  0,     0, 0,  0,       10'h012, 1, 0, 1)); // underflow
      tbl.push_back(mk(1, 0, NONE,    0, 0,  0,     0, 0,  0,       10'h000, 1, 0, 0));
      tbl.push_back(mk(0, 0, JMP_ABS, 1, 2,  0,     0, 0,  0,       10'h010, 1, 0, 0));
      tbl.push_back(mk(0, 0, CALL,    0, 3,  0,     0, 0,  0,       10'h020, 1, 0, 0));
      tbl.push_back(mk(0, 0, CALL,    0, 4,  0,     0, 0,  0,       10'h030, 1, 0, 0));
      tbl.push_back(mk(0, 0, CALL,    0, 6,  0,     0, 0,  0,       10'h040, 1, 0, 0));
      tbl.push_back(mk(0, 0, CALL,    0, 7,  0,     0, 0,  0,       10'h050, 1, 0, 0));
      tbl.push_back(mk(0, 0, CALL,    0, 8,  0,     0, 0,  0,       10'h100, 1, 0, 1)); // overflow, jump taken
      tbl.push_back(mk(0, 0, RET,     0, 0,  0,     0, 0,  0,       10'h041, 1, 0, 1));
      tbl.push_back(mk(0, 1, JMP_ABS, 1, 2,  0,     1, 9,  10'h0AA, 10'h041, 1, 0, 1)); // stall, write lands
      tbl.push_back(mk(0, 0, JMP_ABS, 1, 9,  0,     0, 0,  0,       10'h0AA, 1, 0, 1));
      tbl.push_back(mk(0, 1, RET,     0, 0,  0,     0, 0,  0,       10'h0AA, 1, 0, 1));
      tbl.push_back(mk(0, 0, RET,     0, 0,  0,     0, 0,  0,       10'h031, 1, 0, 1));
      tbl.push_back(mk(1, 0, NONE,    0, 0,  0,     0, 0,  0,       10'h000, 1, 0, 0));
      tbl.push_back(mk(0, 0, JMP_ABS, 1, 7,  0,     0, 0,  0,       10'h050, 1, 0, 0));
      tbl.push_back(mk(0, 0, HALT,    0, 0,  0,     0, 0,  0,       10'h050, 0, 1, 0));
      tbl.push_back(mk(0, 0, JMP_ABS, 1, 2,  0,     0, 0,  0,       10'h050, 0, 1, 0));
      tbl.push_back(mk(1, 0, NONE,    0, 0,  0,     0, 0,  0,       10'h000, 1, 0, 0));
      tbl.push_back(mk(0, 0, JMP_ABS, 1, 10, 0,     0, 0,  0,       10'h00E, 1, 0, 0));
      tbl.push_back(mk(0, 0, NONE,    0, 0,  0,     0, 0,  0,       10'h00F, 1, 0, 0));
      tbl.push_back(mk(0, 0, JMP_REL, 1, 0,  0,     0, 0,  0,       10'h00F, 1, 0, 0)); // taken at last: no halt
      tbl.push_back(mk(0, 0, JMP_ABS, 0, 2,  0,     0, 0,  0,       10'h00F, 0, 1, 0)); // not taken at last: halt
      tbl.push_back(mk(1, 1, HALT,    0, 0,  0,     0, 0,  0,       10'h000, 1, 0, 0));
      tbl.push_back(mk(0, 0, JMP_ABS, 1, 10, 0,     0, 0,  0,       10'h00E, 1, 0, 0));
      tbl.push_back(mk(0, 0, NONE,    0, 0,  0,     0, 0,  0,       10'h00F, 1, 0, 0));
      tbl.push_back(mk(0, 0, NONE,    0, 0,  0,     0, 0,  0,       10'h00F, 0, 1, 0));
      drive(mk(0, 0, NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #1 check("reset_state", 10'h000, 0, 0, 0);
      @(negedge clk) reset = 1'b0;
      foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i));
      step(mk(1, 0, NONE, 0, 0, 0, 0, 0, 0, 10'h000, 1, 0, 0), "restart");
      step(mk(0, 0, NONE, 0, 0, 0, 0, 0, 0, 10'h001, 1, 0, 0), "run_a");
      step(mk(0, 0, NONE, 0, 0, 0, 0, 0, 0, 10'h002, 1, 0, 0), "run_b");
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check("async_reset", 10'h000, 0, 0, 0);
      @(negedge clk) reset = 1'b0;
      step(mk(1, 0, NONE, 0, 0, 0, 0, 0, 0, 10'h000, 1, 0, 0), "post_reset_start");
      step(mk(0, 0, JMP_ABS, 1, 5, 0, 0, 0, 0, 10'h000, 1, 0, 0), "lut_cleared");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
